// File: rtl/rv_fetch_pkg.sv
// Shared encodings, FSM state type and immediate decoders for the fetch stage.
// Consumed by instruction_fetch_unit.
package rv_fetch_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNEQ = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;

  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Sign-extended B-type offset (bit 0 always zero).
  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  // Sign-extended J-type offset (bit 0 always zero).
  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/instr_memory.sv
// Word-addressed instruction store: one synchronous write port, one
// combinational read port so the core sees the instruction in the same cycle.
module instr_memory #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  // NOTE: the array has no reset branch; a program loaded once must survive
  // rst, and resetting a RAM would also block mapping it onto memory macros.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, run/halt FSM, program-load port and next-PC
// selection from jump/branch controls for a single-cycle core.
module instruction_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int          IMEM_DEPTH = 64,
  parameter int          IMEM_AW    = $clog2(IMEM_DEPTH),
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  input  logic               prog_we,
  input  logic [IMEM_AW-1:0] prog_addr,
  input  logic [31:0]        prog_data,
  input  logic               jump,
  input  logic               beq,
  input  logic               bneq,
  input  logic               bge,
  input  logic               blt,
  output logic [31:0]        pc,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic               halted,
  output logic               fetch_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fetch_err_q, fetch_err_d;

  logic [31:0]  imem_rdata;
  logic [31:0]  pc_next;
  logic         branch_taken;
  logic         next_bad;

  instr_memory #(
    .DEPTH(IMEM_DEPTH),
    .AW   (IMEM_AW)
  ) u_imem (
    .clk  (clk),
    .we   (prog_we && (state_q == IDLE)),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(pc_q[IMEM_AW+1:2]),
    .rdata(imem_rdata)
  );

  assign instr = (state_q == RUN) ? imem_rdata : INSTR_NOP;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned (which would infer a latch); blocking '=' here,
  // non-blocking '<=' only in the clocked block.
  always_comb begin
    branch_taken = 1'b0;
    case (instr[14:12])
      F3_BEQ:  branch_taken = beq;
      F3_BNEQ: branch_taken = bneq;
      F3_BLT:  branch_taken = blt;
      F3_BGE:  branch_taken = bge;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_next = pc_q + 32'd4;
    if ((instr[6:0] == OP_JAL) && jump) begin
      pc_next = pc_q + imm_j(instr);
    end else if ((instr[6:0] == OP_BRANCH) && branch_taken) begin
      pc_next = pc_q + imm_b(instr);
    end
  end

  // Misaligned, or a word index beyond the array (covers falling off the end).
  assign next_bad = (pc_next[1:0] != 2'b00) || (pc_next[31:IMEM_AW+2] != '0);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_err_d = fetch_err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = RESET_PC;
        end
      end
      RUN: begin
        if (!stall) begin
          if (instr == INSTR_EBREAK) begin
            state_d = HALT;
          end else if (next_bad) begin
            state_d     = HALT;
            fetch_err_d = 1'b1;
          end else begin
            pc_d = pc_next;
          end
        end
      end
      HALT: begin
        if (start) begin
          state_d     = RUN;
          pc_d        = RESET_PC;
          fetch_err_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign pc          = pc_q;
  assign instr_valid = (state_q == RUN) && !stall;
  assign halted      = (state_q == HALT);
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: an architectural model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBRK   = 32'h0010_0073;
  localparam logic [31:0] ADDI1  = 32'h0010_0093;  // addi x1,x0,1
  localparam logic [31:0] ADDI2  = 32'h0020_0113;  // addi x2,x0,2
  localparam logic [31:0] BEQ8   = 32'h0000_0463;  // beq  x0,x0,+8
  localparam logic [31:0] BNE8   = 32'h0000_1463;  // bne  x0,x0,+8
  localparam logic [31:0] BEQ2   = 32'h0000_0163;  // beq  x0,x0,+2
  localparam logic [31:0] JALM16 = 32'hFF1F_F06F;  // jal  x0,-16

  logic        clk = 1'b0;
  logic        rst, start, stall, prog_we, jump, beq, bneq, bge, blt;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data;
  logic [31:0] pc, instr;
  logic        instr_valid, halted, fetch_err;

  int total = 0;
  int bad   = 0;

  instruction_fetch_unit dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .jump(jump), .beq(beq), .bneq(bneq), .bge(bge), .blt(blt),
    .pc(pc), .instr(instr), .instr_valid(instr_valid),
    .halted(halted), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- architectural model ----------------
  // m_mode: 0 idle, 1 running, 2 halted
  logic [31:0] m_mem [64];
  int          m_mode = 0;
  logic [31:0] m_pc   = '0;
  logic        m_err  = 1'b0;
  bit          m_live = 1'b0;

  function automatic logic [31:0] m_instr();
    return (m_mode == 1) ? m_mem[int'(m_pc >> 2)] : NOP;
  endfunction

  task automatic m_execute();
    logic [31:0] w, tgt;
    int sgn, off;
    bit take;
    w    = m_mem[int'(m_pc >> 2)];
    sgn  = w[31] ? -1 : 0;
    tgt  = m_pc + 32'd4;
    take = 1'b0;
    if (w == EBRK) begin
      m_mode = 2;
      return;
    end
    if (w[6:0] == 7'd111 && jump) begin
      off = sgn * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
      tgt = m_pc + 32'(off);
    end else if (w[6:0] == 7'd99) begin
      case (int'(w[14:12]))
        0: take = beq;
        1: take = bneq;
        4: take = blt;
        5: take = bge;
        default: take = 1'b0;
      endcase
      if (take) begin
        off = sgn * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        tgt = m_pc + 32'(off);
      end
    end
    if ((tgt % 4) != 0 || (tgt / 4) >= 64) begin
      m_err  = 1'b1;
      m_mode = 2;
    end else begin
      m_pc = tgt;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0;
      m_pc   = '0;
      m_err  = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      case (m_mode)
        0: begin
          if (prog_we) m_mem[int'(prog_addr)] = prog_data;
          if (start) begin m_mode = 1; m_pc = '0; end
        end
        1: if (!stall) m_execute();
        default: if (start) begin m_mode = 1; m_pc = '0; m_err = 1'b0; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("pc", pc, m_pc);
      check("instr", instr, m_instr());
      check("instr_valid", 32'(instr_valid), 32'((m_mode == 1) && !stall));
      check("halted", 32'(halted), 32'(m_mode == 2));
      check("fetch_err", 32'(fetch_err), 32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [31:0] data);
    prog_we   = 1'b1;
    prog_addr = 6'(addr);
    prog_data = data;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 0; stall = 0; prog_we = 0; prog_addr = '0; prog_data = '0;
    jump = 0; beq = 0; bneq = 0; bge = 0; blt = 0;
    tick();
    rst = 1'b0;
    check("reset_pc", pc, 32'h0);
    check("reset_instr", instr, NOP);
    check("reset_halted", 32'(halted), 32'h0);
    check("reset_valid", 32'(instr_valid), 32'h0);
    for (int i = 0; i < 64; i++) load(i, NOP);

    // A: straight-line program; last write coincides with start
    load(0, ADDI1);
    load(1, ADDI2);
    prog_we = 1'b1; prog_addr = 6'd2; prog_data = EBRK; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    check("A_pc0", pc, 32'h0);
    check("A_instr0", instr, ADDI1);
    check("A_valid0", 32'(instr_valid), 32'h1);
    tick(); check("A_pc4", pc, 32'h4);
    tick(); check("A_pc8", pc, 32'h8); check("A_instr8", instr, EBRK);
    stall = 1'b1;
    tick(); check("A_stall_no_halt", 32'(halted), 32'h0);
    stall = 1'b0;
    tick(); check("A_halted", 32'(halted), 32'h1); check("A_pc_hold", pc, 32'h8);
    tick(); check("A_pc_hold2", pc, 32'h8);

    // B: conditional branches
    do_reset();
    load(0, NOP); load(1, BEQ8); load(3, EBRK);
    beq = 1'b1;
    pulse_start();
    tick(); check("B_at_beq", instr, BEQ8);
    tick(); check("B_beq_taken", pc, 32'hC);
    tick();
    beq = 1'b0;
    pulse_start(); check("B_restart_pc", pc, 32'h0);
    tick(); tick(); check("B_beq_not_taken", pc, 32'h8);
    tick();
    do_reset();
    load(1, BNE8);
    beq = 1'b1; bneq = 1'b0;
    pulse_start(); tick(); tick();
    check("B_bneq_not_taken", pc, 32'h8);
    tick();
    beq = 1'b0;

    // C: JAL backwards, then the same JAL with jump=0
    do_reset();
    load(2, NOP); load(3, NOP); load(4, JALM16); load(5, EBRK);
    jump = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) tick();
    check("C_at_jal", instr, JALM16);
    tick(); check("C_jal_taken", pc, 32'h0);
    jump = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("C_jal_ignored", pc, 32'h14);
    tick(); check("C_halt_at_ebreak", 32'(halted), 32'h1);

    // D: misaligned target, recovery, then fall-through past the last word
    do_reset();
    load(0, NOP); load(1, BEQ2);
    for (int i = 2; i < 6; i++) load(i, NOP);
    beq = 1'b1;
    pulse_start(); tick(); tick();
    check("D_err", 32'(fetch_err), 32'h1);
    check("D_err_halted", 32'(halted), 32'h1);
    check("D_err_pc_hold", pc, 32'h4);
    beq = 1'b0;
    pulse_start();
    check("D_restart_pc", pc, 32'h0);
    check("D_err_cleared", 32'(fetch_err), 32'h0);
    for (int i = 0; i < 80; i++) begin
      tick();
      if (halted) break;
    end
    check("D_end_halted", 32'(halted), 32'h1);
    check("D_end_pc", pc, 32'hFC);
    check("D_end_err", 32'(fetch_err), 32'h1);

    // E: stall on a branch, program writes during RUN, reset mid-run
    pulse_start(); tick();
    check("E_pc4", pc, 32'h4);
    stall = 1'b1; beq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("E_stall_pc", pc, 32'h4);
      check("E_stall_instr", instr, BEQ2);
      check("E_stall_valid", 32'(instr_valid), 32'h0);
    end
    stall = 1'b0; beq = 1'b0;
    tick(); check("E_resume", pc, 32'h8);
    prog_we = 1'b1; prog_addr = 6'd10; prog_data = EBRK;
    tick(); prog_we = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("E_pc20", pc, 32'h20);
    do_reset();
    check("E_rst_pc", pc, 32'h0);
    check("E_rst_instr", instr, NOP);
    check("E_rst_valid", 32'(instr_valid), 32'h0);
    check("E_rst_halted", 32'(halted), 32'h0);
    pulse_start();
    check("E_rerun_instr1", instr, NOP);
    tick(); check("E_rerun_beq", instr, BEQ2);
    for (int i = 0; i < 9; i++) tick();
    check("E_word10_pc", pc, 32'h28);
    check("E_word10_unchanged", instr, NOP);
    tick(); check("E_past_word10", pc, 32'h2C);
    check("E_not_halted", 32'(halted), 32'h0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
